// File: rtl/dmem_lsu_pkg.sv
// -----------------------------------------------------------------------------
// dmem_lsu_pkg
// Shared definitions for the data-memory load/store unit.
//   - SZ_* : request size encoding carried on req_size
//   - state_e : top-level controller state (INIT sweep, RUN service)
//   - byte_en / st_lanes : store byte-enable and lane-replication helpers
// -----------------------------------------------------------------------------
package dmem_lsu_pkg;

  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_ILL = 2'b11;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Byte lanes touched by a store of the given size at the given byte offset.
  function automatic logic [3:0] byte_en(input logic [1:0] size,
                                         input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << lo;
      SZ_H:    be = lo[1] ? 4'b1100 : 4'b0011;
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Right-aligned store data replicated onto every lane it could land in, so
  // the byte enables alone pick the destination.
  function automatic logic [31:0] st_lanes(input logic [1:0]  size,
                                           input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      SZ_B:    d = {4{wdata[7:0]}};
      SZ_H:    d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dmem_lsu_ldfmt.sv
// -----------------------------------------------------------------------------
// dmem_lsu_ldfmt
// Purely combinational load formatter: selects the byte/half/word addressed by
// the low address bits out of a 32-bit memory word and sign- or zero-extends.
// Ports:
//   i_addr_lo  [1:0]  byte offset within the word
//   i_size     [1:0]  SZ_B / SZ_H / SZ_W (SZ_ILL yields 0)
//   i_unsigned        1 = zero-extend, 0 = sign-extend
//   i_word     [31:0] raw memory word
//   o_result   [31:0] extended load value
// -----------------------------------------------------------------------------
module dmem_lsu_ldfmt
  import dmem_lsu_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_word,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = 8'(i_word >> {i_addr_lo, 3'b000});
  assign w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_result = '0;
    case (i_size)
      SZ_B:    o_result = i_unsigned ? {24'h0, w_byte}
                                     : {{24{w_byte[7]}}, w_byte};
      SZ_H:    o_result = i_unsigned ? {16'h0, w_half}
                                     : {{16{w_half[15]}}, w_half};
      SZ_W:    o_result = i_word;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// -----------------------------------------------------------------------------
// dmem_lsu
// Single-port data memory with a load/store request interface. After reset an
// INIT sweep writes zero to every word (one per cycle); the block then sits in
// RUN and accepts one request per cycle with no back-pressure.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both 1. Every transferred request (load or store, good or bad)
// yields exactly one single-cycle rsp_valid pulse in the next cycle; rsp_rdata
// and rsp_err are meaningful only while rsp_valid=1 and hold otherwise.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_we                1 store, 0 load
//   req_size [1:0]        SZ_B / SZ_H / SZ_W / SZ_ILL
//   req_unsigned          load zero-extend (1) or sign-extend (0)
//   req_addr [ADDR_W-1:0] byte address
//   req_wdata [31:0]      right-aligned store data
//   rsp_valid             response pulse
//   rsp_rdata [31:0]      extended load data (0 for stores and errors)
//   rsp_err               request was rejected
//   init_done             clear sweep finished
//   dbg_state             controller state, for observation
// -----------------------------------------------------------------------------
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              init_done,
  output state_e            dbg_state
);

  localparam int AW = $clog2(DEPTH);

  // ---------------------------------------------------------------------------
  // Controller FSM
  // ---------------------------------------------------------------------------
  state_e        r_state;
  state_e        w_state_nxt;
  logic [AW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == INIT) r_cnt <= r_cnt + AW'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == INIT && r_cnt == AW'(DEPTH - 1)) w_state_nxt = RUN;
  end

  always_comb begin
    req_ready = (r_state == RUN);
    init_done = (r_state == RUN);
  end

  assign dbg_state = r_state;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic          w_accept;
  logic [AW-1:0] w_idx;
  logic          w_oor;
  logic          w_misalign;
  logic          w_err;
  logic [3:0]    w_st_be;

  assign w_accept   = req_valid & req_ready;
  assign w_idx      = req_addr[AW+1:2];
  // Any address bit above the word index makes the access out of range.
  assign w_oor      = |(req_addr >> (AW + 2));
  assign w_misalign = ((req_size == SZ_H) &&  req_addr[0]) ||
                      ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
  assign w_err      = w_oor | w_misalign | (req_size == SZ_ILL);
  assign w_st_be    = byte_en(req_size, req_addr[1:0]) &
                      {4{w_accept & req_we & ~w_err}};

  // ---------------------------------------------------------------------------
  // Storage: one write port shared by the sweep and stores, one read port.
  // The sweep owns the write port in INIT; requests are never accepted then.
  // ---------------------------------------------------------------------------
  logic [31:0]   r_mem [DEPTH];
  logic [31:0]   r_rd_word;
  logic [3:0]    w_mem_be;
  logic [AW-1:0] w_mem_idx;
  logic [31:0]   w_mem_wdata;

  always_comb begin
    w_mem_be    = w_st_be;
    w_mem_idx   = w_idx;
    w_mem_wdata = st_lanes(req_size, req_wdata);
    if (r_state == INIT) begin
      w_mem_be    = 4'b1111;
      w_mem_idx   = r_cnt;
      w_mem_wdata = '0;
    end
  end

  // No reset here: contents are cleared only by the sweep.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_mem_be[b]) r_mem[w_mem_idx][8*b +: 8] <= w_mem_wdata[8*b +: 8];
    end
    if (w_accept) r_rd_word <= r_mem[w_idx];
  end

  // ---------------------------------------------------------------------------
  // Response registers. Load formatting is applied after the read register;
  // r_ld_ok forces rdata to zero for stores, errors and out of reset.
  // ---------------------------------------------------------------------------
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic        r_ld_ok;
  logic [1:0]  r_lo;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [31:0] w_fmt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_ld_ok     <= 1'b0;
      r_lo        <= '0;
      r_size      <= '0;
      r_uns       <= 1'b0;
    end else begin
      r_rsp_valid <= w_accept;
      if (w_accept) begin
        r_rsp_err <= w_err;
        r_ld_ok   <= ~req_we & ~w_err;
        r_lo      <= req_addr[1:0];
        r_size    <= req_size;
        r_uns     <= req_unsigned;
      end
    end
  end

  dmem_lsu_ldfmt u_ldfmt (
    .i_addr_lo  (r_lo),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .i_word     (r_rd_word),
    .o_result   (w_fmt)
  );

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_ld_ok ? w_fmt : 32'h0;

endmodule

// File: tb/tb_dmem_lsu.sv
// -----------------------------------------------------------------------------
// tb_dmem_lsu
// Directed vector table, back-to-back and mid-stream reset sequences, and a
// random phase checked against a behavioural memory model. Expected responses
// are queued when a request is driven and compared when rsp_valid appears.
// -----------------------------------------------------------------------------
module tb_dmem_lsu;
  import dmem_lsu_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = SZ_W;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_done;
  state_e      dbg_state;

  always #5 clk = ~clk;

  dmem_lsu #(.DEPTH(16), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .init_done    (init_done),
    .dbg_state    (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int          errors = 0;
  int          checks = 0;
  int          rsp_n  = 0;
  logic [32:0] exp_q[$];       // {err, rdata}
  logic [31:0] mem_m [16];

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h, required %08h", name, got, exp);
    end
  endtask

  task automatic report();
    $display("Result: errors=%0d of %0d checks", errors, checks);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model of the memory and load/store semantics
  // ---------------------------------------------------------------------------
  function automatic logic [32:0] model_op(input logic we, input logic [1:0] sz,
                                           input logic uns, input logic [31:0] addr,
                                           input logic [31:0] wd);
    logic        err;
    logic [3:0]  idx;
    logic [1:0]  lo;
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    lo  = addr[1:0];
    err = (sz == 2'b11) || (addr >= 32'd64) ||
          (sz == 2'b01 && addr[0]) || (sz == 2'b10 && lo != 2'b00);
    if (err) return {1'b1, 32'h0};
    idx = addr[5:2];
    w   = mem_m[idx];
    if (we) begin
      case (sz)
        2'b00:   w[8*lo +: 8] = wd[7:0];
        2'b01:   w[16*lo[1] +: 16] = wd[15:0];
        default: w = wd;
      endcase
      mem_m[idx] = w;
      return {1'b0, 32'h0};
    end
    b = w[8*lo +: 8];
    h = w[16*lo[1] +: 16];
    case (sz)
      2'b00:   r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return {1'b0, r};
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic push, input logic [32:0] exp);
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    if (push) exp_q.push_back(exp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  // Called at a negedge with rst_n low: releases reset and counts not-ready cycles.
  task automatic release_and_count();
    int cnt;
    rst_n = 1'b1;
    cnt   = 0;
    while (!req_ready && cnt < 64) begin
      cnt++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("ready_low_cycles", 32'(cnt), 32'd16);
    check("init_done_after_sweep", {31'h0, init_done}, 32'h1);
    check("state_run", {31'h0, dbg_state}, {31'h0, RUN});
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rsp_valid) begin
      logic [32:0] e;
      checks++;
      rsp_n++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected#%0d: got err=%0b rdata=%08h, required no response",
                 rsp_n, rsp_err, rsp_rdata);
      end else begin
        e = exp_q.pop_front();
        if ({rsp_err, rsp_rdata} !== e) begin
          errors++;
          $display("FAIL rsp#%0d: got err=%0b rdata=%08h, required err=%0b rdata=%08h",
                   rsp_n, rsp_err, rsp_rdata, e[32], e[31:0]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        err;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic we, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic err, input logic [31:0] rd);
    vec_t v;
    v.we = we; v.sz = sz; v.uns = uns; v.addr = addr;
    v.wd = wd; v.err = err; v.rd = rd;
    vecs.push_back(v);
  endfunction

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout, required completion");
    report();
    $finish;
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] last_rd;
    logic [32:0] e;

    add(0, SZ_W,   0, 32'h0000_0000, 32'h0,         0, 32'h0000_0000);
    add(0, SZ_W,   0, 32'h0000_003C, 32'h0,         0, 32'h0000_0000);
    add(1, SZ_W,   0, 32'h0000_0008, 32'h8081_F2F3, 0, 32'h0000_0000);
    add(0, SZ_B,   0, 32'h0000_0009, 32'h0,         0, 32'hFFFF_FFF2);
    add(0, SZ_B,   1, 32'h0000_0009, 32'h0,         0, 32'h0000_00F2);
    add(0, SZ_H,   0, 32'h0000_000A, 32'h0,         0, 32'hFFFF_8081);
    add(0, SZ_H,   1, 32'h0000_000A, 32'h0,         0, 32'h0000_8081);
    add(0, SZ_W,   0, 32'h0000_0008, 32'h0,         0, 32'h8081_F2F3);
    add(0, SZ_B,   0, 32'h0000_000B, 32'h0,         0, 32'hFFFF_FF80);
    add(0, SZ_B,   1, 32'h0000_0008, 32'h0,         0, 32'h0000_00F3);
    add(1, SZ_W,   0, 32'h0000_0004, 32'h1122_3344, 0, 32'h0000_0000);
    add(1, SZ_B,   0, 32'h0000_0005, 32'hFFFF_FFAA, 0, 32'h0000_0000);
    add(0, SZ_W,   0, 32'h0000_0004, 32'h0,         0, 32'h1122_AA44);
    add(1, SZ_W,   0, 32'h0000_0000, 32'hDEAD_BEEF, 0, 32'h0000_0000);
    add(1, SZ_H,   0, 32'h0000_0003, 32'h0000_5555, 1, 32'h0000_0000);
    add(1, SZ_W,   0, 32'h0000_0006, 32'h5555_5555, 1, 32'h0000_0000);
    add(1, SZ_ILL, 0, 32'h0000_0000, 32'h5555_5555, 1, 32'h0000_0000);
    add(0, SZ_W,   0, 32'h0000_0000, 32'h0,         0, 32'hDEAD_BEEF);
    add(0, SZ_W,   0, 32'h0000_0004, 32'h0,         0, 32'h1122_AA44);
    add(0, SZ_W,   0, 32'h0000_0040, 32'h0,         1, 32'h0000_0000);
    add(0, SZ_B,   0, 32'h8000_0008, 32'h0,         1, 32'h0000_0000);
    add(0, SZ_ILL, 0, 32'h0000_0008, 32'h0,         1, 32'h0000_0000);
    add(0, SZ_H,   0, 32'h0000_0001, 32'h0,         1, 32'h0000_0000);
    add(0, SZ_W,   0, 32'h0000_0002, 32'h0,         1, 32'h0000_0000);
    add(1, SZ_H,   0, 32'h0000_0006, 32'h0000_BEEF, 0, 32'h0000_0000);
    add(0, SZ_W,   0, 32'h0000_0004, 32'h0,         0, 32'hBEEF_AA44);
    add(0, SZ_H,   0, 32'h0000_0004, 32'h0,         0, 32'hFFFF_AA44);
    add(1, SZ_H,   0, 32'h0000_0002, 32'hFFFF_1234, 0, 32'h0000_0000);
    add(0, SZ_H,   1, 32'h0000_0002, 32'h0,         0, 32'h0000_1234);
    add(0, SZ_B,   1, 32'h0000_0003, 32'h0,         0, 32'h0000_0012);
    add(0, SZ_W,   0, 32'h0000_0000, 32'h0,         0, 32'h1234_BEEF);
    add(1, SZ_B,   0, 32'h0000_003F, 32'h0000_0080, 0, 32'h0000_0000);
    add(0, SZ_B,   0, 32'h0000_003F, 32'h0,         0, 32'hFFFF_FF80);
    add(0, SZ_W,   0, 32'h0000_003C, 32'h0,         0, 32'h8000_0000);

    // Reset state, with a store held on the request port that must be ignored.
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'h0, req_ready}, 32'h0);
    check("rst_init_done", {31'h0, init_done}, 32'h0);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err",   {31'h0, rsp_err}, 32'h0);
    check("rst_state",     {31'h0, dbg_state}, {31'h0, INIT});
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = SZ_W;
    req_addr  = 32'h0;
    req_wdata = 32'hFFFF_FFFF;
    release_and_count();
    clear_model();

    // Directed table, issued back to back.
    last_rd = '0;
    foreach (vecs[i]) begin
      e = model_op(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd);
      drive(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd,
            1'b1, {vecs[i].err, vecs[i].rd});
      last_rd = vecs[i].rd;
    end
    idle(3);
    check("hold_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("hold_rsp_rdata", rsp_rdata, last_rd);
    check("hold_rsp_err",   {31'h0, rsp_err}, 32'h0);

    // Store then immediate load of the same word.
    e = model_op(1'b1, SZ_W, 1'b0, 32'h0, 32'h7);
    drive(1'b1, SZ_W, 1'b0, 32'h0, 32'h7, 1'b1, {1'b0, 32'h0});
    e = model_op(1'b0, SZ_W, 1'b0, 32'h0, 32'h0);
    drive(1'b0, SZ_W, 1'b0, 32'h0, 32'h0, 1'b1, {1'b0, 32'h7});
    check("b2b_pulse1", {31'h0, rsp_valid}, 32'h1);
    idle(1);
    check("b2b_pulse2", {31'h0, rsp_valid}, 32'h1);
    idle(2);

    // Random traffic against the model.
    for (int i = 0; i < 80; i++) begin
      logic        we;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wd;
      we   = 1'($urandom_range(0, 1));
      sz   = ($urandom_range(0, 9) == 0) ? SZ_ILL : 2'($urandom_range(0, 2));
      uns  = 1'($urandom_range(0, 1));
      addr = 32'($urandom_range(0, 'h47));
      wd   = $urandom;
      e    = model_op(we, sz, uns, addr, wd);
      drive(we, sz, uns, addr, wd, 1'b1, e);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(3);
    check("queue_drained_random", 32'(exp_q.size()), 32'h0);

    // Reset mid-stream, in the cycle after a store is accepted.
    e = model_op(1'b1, SZ_W, 1'b0, 32'h10, 32'hCAFE_F00D);
    drive(1'b1, SZ_W, 1'b0, 32'h10, 32'hCAFE_F00D, 1'b1, {1'b0, 32'h0});
    drive(1'b1, SZ_W, 1'b0, 32'h14, 32'h1234_5678, 1'b0, 33'h0);
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    #1;
    check("mid_rst_req_ready", {31'h0, req_ready}, 32'h0);
    check("mid_rst_init_done", {31'h0, init_done}, 32'h0);
    check("mid_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("mid_rst_rsp_rdata", rsp_rdata, 32'h0);
    check("mid_rst_rsp_err",   {31'h0, rsp_err}, 32'h0);
    check("mid_rst_state",     {31'h0, dbg_state}, {31'h0, INIT});
    repeat (3) @(negedge clk);
    release_and_count();
    clear_model();
    for (int w = 0; w < 16; w++) begin
      e = model_op(1'b0, SZ_W, 1'b0, 32'(w * 4), 32'h0);
      drive(1'b0, SZ_W, 1'b0, 32'(w * 4), 32'h0, 1'b1, e);
    end
    idle(3);
    check("queue_drained_final", 32'(exp_q.size()), 32'h0);

    report();
    $finish;
  end

endmodule
